// File: rtl/instruction_cache.sv
// ----------------------------------------------------------------------------
// instruction_cache
//   Direct-mapped, read-only instruction cache between the fetch stage and a
//   128-bit block instruction memory. Hits return the selected 32-bit word
//   combinationally with no added latency. A miss fetches the whole 16-byte
//   block and stalls the pipeline through cpu_busywait until it is installed.
//
// Ports
//   clock            system clock, all state updates on posedge
//   reset            synchronous, active-low
//   cpu_read         fetch request for cpu_address
//   cpu_address      byte PC: [3:2] word, [4+:INDEX_BITS] index, rest tag
//   cpu_instruction  selected word, valid while cpu_busywait==0
//   cpu_busywait     stall request to the pipeline
//   mem_read         block read request to instruction memory
//   mem_address      block address of the outstanding/last miss
//   mem_readdata     block from memory, byte 0 in bits [7:0]
//   mem_busywait     memory busy; block valid when it falls with mem_read high
// ----------------------------------------------------------------------------
module instruction_cache #(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 28 - INDEX_BITS
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         cpu_read,
   input  logic [31:0]  cpu_address,
   output logic [31:0]  cpu_instruction,
   output logic         cpu_busywait,
   output logic         mem_read,
   output logic [27:0]  mem_address,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
);

   localparam int NUM_LINES = 2 ** INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_t;

   state_t                state;
   logic [NUM_LINES-1:0]  valid;
   logic [TAG_BITS-1:0]   tag_arr  [NUM_LINES];
   logic [127:0]          data_arr [NUM_LINES];
   logic [27:0]           miss_block;
   logic [127:0]          fill_data_p1;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic [1:0]            word_sel;
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TAG_BITS-1:0]   fill_tag;
   logic [1:0]            unused_byte_sel;
   logic [127:0]          line;
   logic                  hit;

   assign idx             = cpu_address[4 +: INDEX_BITS];
   assign tag             = cpu_address[31 -: TAG_BITS];
   assign word_sel        = cpu_address[3:2];
   assign unused_byte_sel = cpu_address[1:0];
   assign fill_idx        = miss_block[INDEX_BITS-1:0];
   assign fill_tag        = miss_block[27 -: TAG_BITS];

   // Hit/miss always looks at the live address, never at the latched miss.
   assign hit          = cpu_read & valid[idx] & (tag_arr[idx] == tag);
   assign cpu_busywait = (state != IDLE) | (cpu_read & ~hit);
   assign mem_address  = miss_block;
   assign line         = data_arr[idx];

   always_comb begin
      cpu_instruction = line[31:0];
      case (word_sel)
         2'd0: cpu_instruction = line[31:0];
         2'd1: cpu_instruction = line[63:32];
         2'd2: cpu_instruction = line[95:64];
         2'd3: cpu_instruction = line[127:96];
         default: cpu_instruction = line[31:0];
      endcase
   end

   // Control: state, valid bits, request and latched miss block.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         valid      <= '0;
         mem_read   <= 1'b0;
         miss_block <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_read && !hit) begin
                  miss_block <= cpu_address[31:4];
                  mem_read   <= 1'b1;
                  state      <= MEM_READ;
               end
            end
            MEM_READ: begin
               if (!mem_busywait) begin
                  mem_read <= 1'b0;
                  state    <= UPDATE;
               end
            end
            UPDATE: begin
               valid[fill_idx] <= 1'b1;
               state           <= IDLE;
            end
            default: begin
               mem_read <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // Data: capture the block on the MEM_READ->UPDATE edge, install it one
   // cycle later. The install is suppressed by reset so an aborted fill never
   // lands in the array.
   always_ff @(posedge clock) begin
      if (state == MEM_READ && !mem_busywait) begin
         fill_data_p1 <= mem_readdata;
      end
      if (reset && state == UPDATE) begin
         data_arr[fill_idx] <= fill_data_p1;
         tag_arr[fill_idx]  <= fill_tag;
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

   logic         clock = 1'b0;
   logic         reset;
   logic         cpu_read;
   logic [31:0]  cpu_address;
   logic [31:0]  cpu_instruction;
   logic         cpu_busywait;
   logic         mem_read;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem_bytes [0:1023];
   int         mem_cnt = 0;
   int         mem_lat = 2;
   logic [127:0] blk;

   instruction_cache dut (
      .clock           (clock),
      .reset           (reset),
      .cpu_read        (cpu_read),
      .cpu_address     (cpu_address),
      .cpu_instruction (cpu_instruction),
      .cpu_busywait    (cpu_busywait),
      .mem_read        (mem_read),
      .mem_address     (mem_address),
      .mem_readdata    (mem_readdata),
      .mem_busywait    (mem_busywait)
   );

   always #5 clock = ~clock;

   // Memory model: busy for mem_lat cycles of mem_read, then presents the
   // block; garbage is driven at all other times.
   always @(posedge clock) begin
      if (mem_read) mem_cnt <= mem_cnt + 1;
      else          mem_cnt <= 0;
   end

   assign mem_busywait = mem_read && (mem_cnt < mem_lat);

   always_comb begin
      blk = '0;
      for (int b = 0; b < 16; b++) begin
         blk[8*b +: 8] = mem_bytes[{mem_address[5:0], 4'b0000} + b];
      end
      mem_readdata = (mem_read && !mem_busywait) ? blk : {4{32'hDEADBEEF}};
   end

   function automatic logic [31:0] gw(input logic [31:0] a);
      int i;
      i = int'(a[9:0]) & ~3;
      return {mem_bytes[i+3], mem_bytes[i+2], mem_bytes[i+1], mem_bytes[i]};
   endfunction

   task automatic set_word(input int a, input logic [31:0] w);
      mem_bytes[a]   = w[7:0];
      mem_bytes[a+1] = w[15:8];
      mem_bytes[a+2] = w[23:16];
      mem_bytes[a+3] = w[31:24];
   endtask

   // Change inputs just after a posedge, return at the following negedge.
   task automatic set_req(input logic rd, input logic [31:0] a);
      @(posedge clock);
      #1;
      cpu_read    = rd;
      cpu_address = a;
      @(negedge clock);
   endtask

   task automatic wait_fill(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clock);
         @(negedge clock);
         cyc++;
         if (!cpu_busywait) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      checks++;
      if (mem_read !== 1'b0) begin
         errors++; $display("FAIL reset_mem_read got %0b want 0", mem_read);
      end
      checks++;
      if (mem_address !== 28'h0) begin
         errors++; $display("FAIL reset_mem_address got %h want 0", mem_address);
      end
      checks++;
      if (cpu_busywait !== 1'b0) begin
         errors++; $display("FAIL reset_busywait got %0b want 0", cpu_busywait);
      end
   endtask

   task automatic test_idle_no_read(input string tag);
      for (int k = 0; k < 10; k++) begin
         set_req(1'b0, 32'(k * 16 + 4));
         checks++;
         if (cpu_busywait !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_noread cyc %0d busywait %0b mem_read %0b want 0 0",
                     tag, k, cpu_busywait, mem_read);
         end
      end
   endtask

   task automatic test_first_miss;
      int cyc; bit ok;
      set_req(1'b1, 32'h0);
      checks++;
      if (cpu_busywait !== 1'b1) begin
         errors++; $display("FAIL miss0_busy got %0b want 1", cpu_busywait);
      end
      @(posedge clock); @(negedge clock);
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 28'h0 || cpu_busywait !== 1'b1) begin
         errors++;
         $display("FAIL miss0_req mem_read %0b addr %h busy %0b want 1 0 1",
                  mem_read, mem_address, cpu_busywait);
      end
      wait_fill(cyc, ok);
      checks++;
      if (!ok || cyc != 4) begin
         errors++; $display("FAIL miss0_latency got %0d (ok %0b) want 4", cyc, ok);
      end
      checks++;
      if (cpu_instruction !== 32'h00500093 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL miss0_data got %h mem_read %0b want 00500093 0",
                  cpu_instruction, mem_read);
      end
   endtask

   task automatic test_hit;
      set_req(1'b1, 32'h4);
      checks++;
      if (cpu_busywait !== 1'b0 || mem_read !== 1'b0 || cpu_instruction !== 32'h00506113) begin
         errors++;
         $display("FAIL hit4 got %h busy %0b mem_read %0b want 00506113 0 0",
                  cpu_instruction, cpu_busywait, mem_read);
      end
      set_req(1'b1, 32'hC);
      checks++;
      if (cpu_busywait !== 1'b0 || mem_read !== 1'b0 || cpu_instruction !== 32'h00000013) begin
         errors++;
         $display("FAIL hitC got %h busy %0b mem_read %0b want 00000013 0 0",
                  cpu_instruction, cpu_busywait, mem_read);
      end
   endtask

   task automatic test_second_line;
      int cyc; bit ok;
      mem_lat = 0;
      set_req(1'b1, 32'h10);
      checks++;
      if (cpu_busywait !== 1'b1) begin
         errors++; $display("FAIL miss10_busy got %0b want 1", cpu_busywait);
      end
      @(posedge clock); @(negedge clock);
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 28'h1) begin
         errors++;
         $display("FAIL miss10_req mem_read %0b addr %h want 1 1", mem_read, mem_address);
      end
      wait_fill(cyc, ok);
      checks++;
      if (!ok || cyc != 2 || cpu_instruction !== 32'h002081B3) begin
         errors++;
         $display("FAIL miss10_data got %h cyc %0d ok %0b want 002081b3 2 1",
                  cpu_instruction, cyc, ok);
      end
      set_req(1'b1, 32'h0);
      checks++;
      if (cpu_busywait !== 1'b0 || mem_read !== 1'b0 || cpu_instruction !== 32'h00500093) begin
         errors++;
         $display("FAIL back0_hit got %h busy %0b mem_read %0b want 00500093 0 0",
                  cpu_instruction, cpu_busywait, mem_read);
      end
   endtask

   task automatic test_conflict;
      int cyc; bit ok;
      mem_lat = 4;
      set_req(1'b1, 32'h80);
      checks++;
      if (cpu_busywait !== 1'b1) begin
         errors++; $display("FAIL conf80_busy got %0b want 1", cpu_busywait);
      end
      @(posedge clock); @(negedge clock);
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 28'h8) begin
         errors++;
         $display("FAIL conf80_req mem_read %0b addr %h want 1 8", mem_read, mem_address);
      end
      wait_fill(cyc, ok);
      checks++;
      if (!ok || cpu_instruction !== gw(32'h80)) begin
         errors++;
         $display("FAIL conf80_data got %h ok %0b want %h", cpu_instruction, ok, gw(32'h80));
      end
      set_req(1'b1, 32'h0);
      checks++;
      if (cpu_busywait !== 1'b1) begin
         errors++; $display("FAIL conf0_busy got %0b want 1", cpu_busywait);
      end
      @(posedge clock); @(negedge clock);
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 28'h0) begin
         errors++;
         $display("FAIL conf0_req mem_read %0b addr %h want 1 0", mem_read, mem_address);
      end
      wait_fill(cyc, ok);
      checks++;
      if (!ok || cpu_instruction !== 32'h00500093) begin
         errors++;
         $display("FAIL conf0_data got %h ok %0b want 00500093", cpu_instruction, ok);
      end
      mem_lat = 2;
   endtask

   task automatic test_reset_midfill;
      int cyc; bit ok;
      mem_lat = 3;
      set_req(1'b1, 32'h20);
      @(posedge clock); @(negedge clock);
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 28'h2) begin
         errors++;
         $display("FAIL rst_mr_req mem_read %0b addr %h want 1 2", mem_read, mem_address);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (mem_read !== 1'b0 || mem_address !== 28'h0) begin
         errors++;
         $display("FAIL rst_mr_drop mem_read %0b addr %h want 0 0", mem_read, mem_address);
      end
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      checks++;
      if (cpu_busywait !== 1'b1) begin
         errors++; $display("FAIL rst_mr_remiss got %0b want 1", cpu_busywait);
      end
      @(posedge clock); @(negedge clock);
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 28'h2) begin
         errors++;
         $display("FAIL rst_mr_rereq mem_read %0b addr %h want 1 2", mem_read, mem_address);
      end
      wait_fill(cyc, ok);
      checks++;
      if (!ok || cpu_instruction !== gw(32'h20)) begin
         errors++;
         $display("FAIL rst_mr_data got %h ok %0b want %h", cpu_instruction, ok, gw(32'h20));
      end
      // Previously valid line 0 must have been invalidated by the reset.
      set_req(1'b1, 32'h0);
      checks++;
      if (cpu_busywait !== 1'b1) begin
         errors++; $display("FAIL rst_line0_busy got %0b want 1", cpu_busywait);
      end
      wait_fill(cyc, ok);
      checks++;
      if (!ok || cpu_instruction !== 32'h00500093) begin
         errors++;
         $display("FAIL rst_line0_data got %h ok %0b want 00500093", cpu_instruction, ok);
      end
      // Reset landing while the FSM sits in UPDATE.
      mem_lat = 0;
      set_req(1'b1, 32'h30);
      @(posedge clock); @(negedge clock);
      checks++;
      if (mem_read !== 1'b1) begin
         errors++; $display("FAIL rst_up_req got %0b want 1", mem_read);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      checks++;
      if (cpu_busywait !== 1'b1 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL rst_up_nowrite busy %0b mem_read %0b want 1 0", cpu_busywait, mem_read);
      end
      wait_fill(cyc, ok);
      checks++;
      if (!ok || cpu_instruction !== gw(32'h30)) begin
         errors++;
         $display("FAIL rst_up_data got %h ok %0b want %h", cpu_instruction, ok, gw(32'h30));
      end
      mem_lat = 2;
   endtask

   task automatic test_hit_sweep;
      int cyc; bit ok;
      logic [31:0] a;
      for (int ln = 0; ln < 8; ln++) begin
         for (int w = 0; w < 4; w++) begin
            a = 32'(ln * 16 + w * 4);
            set_req(1'b1, a);
            ok = 1'b1;
            if (cpu_busywait) wait_fill(cyc, ok);
            checks++;
            if (!ok || cpu_instruction !== gw(a)) begin
               errors++;
               $display("FAIL sweep_%h got %h ok %0b want %h", a, cpu_instruction, ok, gw(a));
            end
         end
      end
   endtask

   initial begin
      reset       = 1'b0;
      cpu_read    = 1'b0;
      cpu_address = 32'h0;
      for (int i = 0; i < 1024; i += 4) set_word(i, 32'hC0DE0000 | 32'(i));
      set_word(32'h00, 32'h00500093);
      set_word(32'h04, 32'h00506113);
      set_word(32'h0C, 32'h00000013);
      set_word(32'h10, 32'h002081B3);

      repeat (2) @(posedge clock);
      @(negedge clock);
      test_reset();
      @(posedge clock);
      #1 reset = 1'b1;
      test_idle_no_read("post_reset");
      test_first_miss();
      test_hit();
      test_second_line();
      test_conflict();
      test_idle_no_read("post_fill");
      test_reset_midfill();
      test_hit_sweep();
      test_idle_no_read("post_sweep");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
